// File: rtl/miner_pkg.sv
// Shared types and widths for the miner job scheduler.
// Contents:
//   HASH_W, NONCE_W, X_W, Y_W  - datapath widths
//   state_t                    - scheduler states (IDLE, SCAN, DRAIN)
//   hit_rec_t                  - queued hit record {hash, nonce}
//   lz_mask()                  - mask covering the top zero_bits bits of a hash
package miner_pkg;

   localparam int HASH_W  = 256;
   localparam int NONCE_W = 32;
   localparam int X_W     = 256;
   localparam int Y_W     = 96;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [HASH_W-1:0]  hash;
      logic [NONCE_W-1:0] nonce;
   } hit_rec_t;

   // Ones in the top zb bits; zb >= 256 yields an all-ones mask.
   function automatic logic [HASH_W-1:0] lz_mask(input logic [8:0] zb);
      return ~({HASH_W{1'b1}} >> zb);
   endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous FIFO of hit records.
// Ports:
//   clk, rst_n   - clock, async active-low reset (reset empties the FIFO)
//   push, din    - write request and record; accepted when not full, or when
//                  a pop in the same cycle frees the slot
//   pop          - read request; ignored while empty
//   full, empty  - occupancy flags
//   head         - oldest record (storage register, valid while !empty)
module hit_fifo
   import miner_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  hit_rec_t din,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output hit_rec_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   hit_rec_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push_ok;
   logic            pop_ok;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_next(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/miner_job_scheduler.sv
// Job controller between the UART receive/transmit path and an array of
// fixed-latency dsha_finisher cores. Latches a job, sweeps a nonce range
// across NUM_CORES cores, tests each qualified result against a runtime
// leading-zero difficulty and queues hits for transmission.
//
// Optional feature macro: MINER_SCHED_STATS_EN adds hash_count[47:0].
//
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   job_valid / job_ready        - job strobe; ready is 1 from the first clk after reset
//   job_x, job_y, job_nonce_start, zero_bits - job contents, sampled with job_valid
//   core_x, core_y               - broadcast to all cores
//   core_nonce                   - per-core input nonce, core i at [32i+31:32i]
//   core_hash, core_out_nonce    - per-core results, PIPE_LATENCY cycles later
//   hit_valid/hit_ready, hit_hash, hit_nonce - hit FIFO head
//   busy, exhausted, drop_count  - status
//   hash_count                   - (MINER_SCHED_STATS_EN) qualified results tested
//
// state | meaning
// IDLE  | no job running, waiting for job_valid
// SCAN  | one nonce per core issued every cycle
// DRAIN | range fully issued, waiting for in-flight results to clear
module miner_job_scheduler
   import miner_pkg::*;
#(
   parameter int NUM_CORES       = 1,
   parameter int PIPE_LATENCY    = 64,
   parameter int NONCE_SPAN_LOG2 = 32,
   parameter int HIT_DEPTH       = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           job_valid,
   output logic                           job_ready,
   input  logic [X_W-1:0]                 job_x,
   input  logic [Y_W-1:0]                 job_y,
   input  logic [NONCE_W-1:0]             job_nonce_start,
   input  logic [8:0]                     zero_bits,
   output logic [X_W-1:0]                 core_x,
   output logic [Y_W-1:0]                 core_y,
   output logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
   input  logic [HASH_W*NUM_CORES-1:0]    core_hash,
   input  logic [NONCE_W*NUM_CORES-1:0]   core_out_nonce,
   output logic                           hit_valid,
   input  logic                           hit_ready,
   output logic [HASH_W-1:0]              hit_hash,
   output logic [NONCE_W-1:0]             hit_nonce,
   output logic                           busy,
   output logic                           exhausted,
   output logic [7:0]                     drop_count
`ifdef MINER_SCHED_STATS_EN
   ,
   output logic [47:0]                    hash_count
`endif
);

   localparam int CNT_W = NONCE_SPAN_LOG2 + 1;
   localparam logic [CNT_W-1:0]   SPAN_FULL = {1'b1, {NONCE_SPAN_LOG2{1'b0}}};
   localparam logic [CNT_W-1:0]   CNT_STEP  = CNT_W'(NUM_CORES);
   localparam logic [NONCE_W-1:0] BASE_STEP = NONCE_W'(NUM_CORES);

   state_t                    state;
   logic [8:0]                zb_q;
   logic [NONCE_W-1:0]        base;
   logic [CNT_W-1:0]          remaining;
   logic [PIPE_LATENCY-1:0]   vpipe;
   logic [PIPE_LATENCY-1:0]   vpipe_nxt;
   logic                      ready_q;
   logic                      issue;
   logic                      q_valid;

   logic [HASH_W-1:0]         mask;
   logic                      any_hit;
   hit_rec_t                  first_rec;
   logic [3:0]                n_extra;

   logic                      cand_valid;
   hit_rec_t                  cand_rec;
   logic [3:0]                cand_extra;

   logic                      push_req;
   logic                      fifo_full;
   logic                      fifo_empty;
   hit_rec_t                  fifo_head;
   logic [3:0]                drop_inc;
   logic [8:0]                drop_sum;

   assign job_ready = ready_q;
   assign busy      = (state != IDLE);

   // A new job overrides the issue slot of the cycle it arrives in.
   assign issue     = (state == SCAN) & ~job_valid;
   assign vpipe_nxt = (vpipe << 1) | PIPE_LATENCY'(issue);
   assign q_valid   = vpipe[PIPE_LATENCY-1] & ~job_valid;

   // Nonces are presented combinationally so the valid bit shifted in at the
   // end of the issue cycle lines up with the core output PIPE_LATENCY later.
   always_comb begin
      core_nonce = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (state == SCAN) core_nonce[NONCE_W*i +: NONCE_W] = base + NONCE_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         core_x    <= '0;
         core_y    <= '0;
         zb_q      <= '0;
         base      <= '0;
         remaining <= '0;
         vpipe     <= '0;
         exhausted <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (job_valid) begin
            core_x    <= job_x;
            core_y    <= job_y;
            zb_q      <= zero_bits;
            base      <= job_nonce_start;
            remaining <= SPAN_FULL;
            vpipe     <= '0;
            exhausted <= 1'b0;
            state     <= SCAN;
         end else begin
            vpipe <= vpipe_nxt;
            case (state)
               SCAN: begin
                  base      <= base + BASE_STEP;
                  remaining <= remaining - CNT_STEP;
                  if (remaining == CNT_STEP) state <= DRAIN;
               end
               DRAIN: begin
                  if (vpipe_nxt == '0) begin
                     state     <= IDLE;
                     exhausted <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign mask = lz_mask(zb_q);

   // Lowest-index hit wins; every other hit in the same cycle is a drop.
   always_comb begin
      any_hit   = 1'b0;
      first_rec = '0;
      n_extra   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if ((core_hash[HASH_W*i +: HASH_W] & mask) == '0) begin
            if (!any_hit) begin
               any_hit         = 1'b1;
               first_rec.hash  = core_hash[HASH_W*i +: HASH_W];
               first_rec.nonce = core_out_nonce[NONCE_W*i +: NONCE_W];
            end else begin
               n_extra = n_extra + 4'd1;
            end
         end
      end
   end

   // Results from an aborted job are never pushed nor counted as drops.
   assign push_req = cand_valid & ~job_valid;
   assign drop_inc = cand_extra + {3'b0, push_req & fifo_full & ~hit_ready};
   assign drop_sum = {1'b0, drop_count} + {5'b0, drop_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_valid <= 1'b0;
         cand_rec   <= '0;
         cand_extra <= '0;
         drop_count <= '0;
      end else begin
         cand_valid <= q_valid & any_hit;
         cand_rec   <= first_rec;
         cand_extra <= q_valid ? n_extra : 4'd0;
         if (job_valid)      drop_count <= '0;
         else if (drop_sum[8]) drop_count <= 8'hFF;
         else                drop_count <= drop_sum[7:0];
      end
   end

   hit_fifo #(
      .DEPTH (HIT_DEPTH)
   ) u_hit_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .din   (cand_rec),
      .pop   (hit_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign hit_valid = ~fifo_empty;
   assign hit_hash  = fifo_head.hash;
   assign hit_nonce = fifo_head.nonce;

`ifdef MINER_SCHED_STATS_EN
   logic [3:0] stat_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_inc   <= '0;
         hash_count <= '0;
      end else begin
         stat_inc   <= q_valid ? 4'(NUM_CORES) : 4'd0;
         hash_count <= hash_count + 48'(stat_inc);
      end
   end
`endif

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Scoreboard bench for miner_job_scheduler. Two instances: u_a (1 core,
// span 8) and u_b (4 cores, span 32), both with a 4-cycle model core and a
// 4-entry hit FIFO. Expected hit nonces are queued when a job is issued; a
// monitor per instance pops and compares on every hit_valid & hit_ready.
module tb_miner_job_scheduler;

   logic          clk;
   logic          rst_n;
   logic [255:0]  job_x;
   logic [95:0]   job_y;
   logic [31:0]   job_start;
   logic [8:0]    zero_bits;

   logic          job_valid_a, job_ready_a, hit_valid_a, hit_ready_a, busy_a, exh_a;
   logic [255:0]  core_x_a, core_hash_a, hit_hash_a;
   logic [95:0]   core_y_a;
   logic [31:0]   core_nonce_a, core_out_nonce_a, hit_nonce_a;
   logic [7:0]    drop_a;

   logic          job_valid_b, job_ready_b, hit_valid_b, hit_ready_b, busy_b, exh_b;
   logic [255:0]  core_x_b, hit_hash_b;
   logic [95:0]   core_y_b;
   logic [127:0]  core_nonce_b, core_out_nonce_b;
   logic [1023:0] core_hash_b;
   logic [31:0]   hit_nonce_b;
   logic [7:0]    drop_b;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   q_a[$];
   logic [31:0]   q_b[$];
   logic [31:0]   e_a, e_b;

   miner_job_scheduler #(.NUM_CORES(1), .PIPE_LATENCY(4), .NONCE_SPAN_LOG2(3), .HIT_DEPTH(4)) u_a (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid_a), .job_ready(job_ready_a),
      .job_x(job_x), .job_y(job_y), .job_nonce_start(job_start), .zero_bits(zero_bits),
      .core_x(core_x_a), .core_y(core_y_a), .core_nonce(core_nonce_a),
      .core_hash(core_hash_a), .core_out_nonce(core_out_nonce_a),
      .hit_valid(hit_valid_a), .hit_ready(hit_ready_a), .hit_hash(hit_hash_a),
      .hit_nonce(hit_nonce_a), .busy(busy_a), .exhausted(exh_a), .drop_count(drop_a));

   miner_job_scheduler #(.NUM_CORES(4), .PIPE_LATENCY(4), .NONCE_SPAN_LOG2(5), .HIT_DEPTH(4)) u_b (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid_b), .job_ready(job_ready_b),
      .job_x(job_x), .job_y(job_y), .job_nonce_start(job_start), .zero_bits(zero_bits),
      .core_x(core_x_b), .core_y(core_y_b), .core_nonce(core_nonce_b),
      .core_hash(core_hash_b), .core_out_nonce(core_out_nonce_b),
      .hit_valid(hit_valid_b), .hit_ready(hit_ready_b), .hit_hash(hit_hash_b),
      .hit_nonce(hit_nonce_b), .busy(busy_b), .exhausted(exh_b), .drop_count(drop_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model cores: 4-stage delay lines of the input nonce.
   logic [31:0] nd_a [4];
   logic [31:0] nd_b [4][4];

   function automatic logic [255:0] hash_a(input logic [31:0] n);
      return {224'h0, n};
   endfunction

   function automatic logic [255:0] hash_b(input logic [31:0] n);
      return (n == 32'h10 || n == 32'h20 || n == 32'h21) ? 256'h0 : {256{1'b1}};
   endfunction

   always @(posedge clk) begin
      nd_a[0] <= core_nonce_a;
      for (int k = 1; k < 4; k++) nd_a[k] <= nd_a[k-1];
      for (int c = 0; c < 4; c++) begin
         nd_b[c][0] <= core_nonce_b[32*c +: 32];
         for (int k = 1; k < 4; k++) nd_b[c][k] <= nd_b[c][k-1];
      end
   end

   assign core_out_nonce_a = nd_a[3];
   assign core_hash_a      = hash_a(nd_a[3]);

   always_comb begin
      core_out_nonce_b = '0;
      core_hash_b      = '0;
      for (int c = 0; c < 4; c++) begin
         core_out_nonce_b[32*c +: 32]  = nd_b[c][3];
         core_hash_b[256*c +: 256]     = hash_b(nd_b[c][3]);
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && hit_valid_a && hit_ready_a) begin
         if (q_a.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL mon_a_unexpected: got nonce %0h, required no hit", hit_nonce_a);
         end else begin
            e_a = q_a.pop_front();
            chk("mon_a_nonce", 256'(hit_nonce_a), 256'(e_a));
            chk("mon_a_hash", hit_hash_a, hash_a(e_a));
         end
      end
      if (rst_n && hit_valid_b && hit_ready_b) begin
         if (q_b.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL mon_b_unexpected: got nonce %0h, required no hit", hit_nonce_b);
         end else begin
            e_b = q_b.pop_front();
            chk("mon_b_nonce", 256'(hit_nonce_b), 256'(e_b));
            chk("mon_b_hash", hit_hash_b, hash_b(e_b));
         end
      end
   end

   // Called at #1 after a posedge; returns at #1 in the first cycle of SCAN.
   task automatic issue_job(input bit sel_b, input logic [31:0] start, input logic [8:0] zb);
      job_start = start;
      zero_bits = zb;
      if (sel_b) job_valid_b = 1'b1;
      else       job_valid_a = 1'b1;
      @(posedge clk); #1;
      job_valid_a = 1'b0;
      job_valid_b = 1'b0;
   endtask

   task automatic wait_idle(input bit sel_b, input string name);
      int k;
      k = 0;
      while ((sel_b ? busy_b : busy_a) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      n_checks++;
      if (sel_b ? busy_b : busy_a) begin
         n_errors++;
         $display("FAIL %s: busy still 1 after 200 cycles, required 0", name);
      end
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      n_checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_errors++;
         $display("FAIL %s: %0d/%0d hits outstanding, required 0/0", name, q_a.size(), q_b.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      job_valid_a = 1'b0; job_valid_b = 1'b0;
      hit_ready_a = 1'b1; hit_ready_b = 1'b1;
      job_x = '0; job_y = '0; job_start = '0; zero_bits = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 256'(busy_a), 256'd0);
      chk("rst_hit_valid", 256'(hit_valid_a), 256'd0);
      chk("rst_exhausted", 256'(exh_a), 256'd0);
      chk("rst_drop", 256'(drop_a), 256'd0);
      chk("rst_core_nonce_a", 256'(core_nonce_a), 256'd0);
      chk("rst_core_nonce_b", 256'(core_nonce_b), 256'd0);
      chk("rst_core_x", core_x_a, 256'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("job_ready_a", 256'(job_ready_a), 256'd1);
      chk("job_ready_b", 256'(job_ready_b), 256'd1);

      // Sweep across the 32-bit wrap, every result a hit.
      job_x = {8{32'hA5A5_0001}};
      job_y = 96'h1234_5678_9ABC_DEF0_0F0F_0F0F;
      q_a.push_back(32'hFFFF_FFFE);
      q_a.push_back(32'hFFFF_FFFF);
      for (int n = 0; n < 6; n++) q_a.push_back(32'(n));
      issue_job(0, 32'hFFFF_FFFE, 9'd0);
      chk("wrap_core_x", core_x_a, {8{32'hA5A5_0001}});
      chk("wrap_core_y", 256'(core_y_a), 256'(96'h1234_5678_9ABC_DEF0_0F0F_0F0F));
      chk("wrap_nonce0", 256'(core_nonce_a), 256'(32'hFFFF_FFFE));
      chk("wrap_busy", 256'(busy_a), 256'd1);
      @(posedge clk); #1;
      chk("wrap_nonce1", 256'(core_nonce_a), 256'(32'hFFFF_FFFF));
      repeat (10) @(posedge clk);
      #1;
      chk("wrap_busy_last", 256'(busy_a), 256'd1);
      @(posedge clk); #1;
      chk("wrap_busy_fall", 256'(busy_a), 256'd0);
      chk("wrap_exhausted", 256'(exh_a), 256'd1);
      wait_drain("wrap_drain");
      chk("wrap_drop", 256'(drop_a), 256'd0);
      chk("wrap_fifo_empty", 256'(hit_valid_a), 256'd0);

      // Abort mid-SCAN with three results in flight.
      for (int n = 0; n < 8; n++) q_a.push_back(32'h200 + 32'(n));
      issue_job(0, 32'h100, 9'd0);
      repeat (3) @(posedge clk);
      #1;
      issue_job(0, 32'h200, 9'd0);
      chk("abort_restart_nonce", 256'(core_nonce_a), 256'(32'h200));
      chk("abort_exh_cleared", 256'(exh_a), 256'd0);
      wait_idle(0, "abort_idle");
      wait_drain("abort_drain");

      // FIFO overflow: six hits (nonces 2..7) into four entries.
      hit_ready_a = 1'b0;
      for (int n = 2; n < 6; n++) q_a.push_back(32'(n));
      issue_job(0, 32'h2, 9'd253);
      wait_idle(0, "ovf_idle");
      chk("ovf_drop", 256'(drop_a), 256'd2);
      chk("ovf_exhausted", 256'(exh_a), 256'd1);
      chk("ovf_hit_valid", 256'(hit_valid_a), 256'd1);
      // Only nonce 0 hits; pop coincides with its push into the full FIFO.
      q_a.push_back(32'h0);
      issue_job(0, 32'h0, 9'd256);
      repeat (5) @(posedge clk);
      #1;
      hit_ready_a = 1'b1;
      @(posedge clk); #1;
      hit_ready_a = 1'b0;
      wait_idle(0, "full_pop_idle");
      chk("full_pop_drop", 256'(drop_a), 256'd0);
      hit_ready_a = 1'b1;
      wait_drain("full_pop_drain");

      // Four cores: single hit at nonce 0x10.
      job_x = {8{32'h5A5A_0002}};
      q_b.push_back(32'h10);
      issue_job(1, 32'h0, 9'd24);
      chk("b_core_nonce", 256'(core_nonce_b), 256'({32'h3, 32'h2, 32'h1, 32'h0}));
      chk("b_core_x", core_x_b, {8{32'h5A5A_0002}});
      chk("b_core_y", 256'(core_y_b), 256'(96'h1234_5678_9ABC_DEF0_0F0F_0F0F));
      wait_idle(1, "b_single_idle");
      wait_drain("b_single_drain");
      chk("b_single_drop", 256'(drop_b), 256'd0);
      chk("b_single_exh", 256'(exh_b), 256'd1);

      // Cores 0 and 1 hit in the same cycle.
      q_b.push_back(32'h20);
      issue_job(1, 32'h20, 9'd24);
      wait_idle(1, "b_dual_idle");
      wait_drain("b_dual_drain");
      chk("b_dual_drop", 256'(drop_b), 256'd1);

      // Reset in DRAIN with a full FIFO and one drop recorded.
      hit_ready_a = 1'b0;
      issue_job(0, 32'h0, 9'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_busy", 256'(busy_a), 256'd1);
      chk("pre_rst_hit_valid", 256'(hit_valid_a), 256'd1);
      chk("pre_rst_drop", 256'(drop_a), 256'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_busy", 256'(busy_a), 256'd0);
      chk("mid_rst_hit_valid", 256'(hit_valid_a), 256'd0);
      chk("mid_rst_exh", 256'(exh_a), 256'd0);
      chk("mid_rst_drop", 256'(drop_a), 256'd0);
      chk("mid_rst_nonce", 256'(core_nonce_a), 256'd0);
      chk("mid_rst_core_x", core_x_a, 256'd0);
      chk("mid_rst_core_y", 256'(core_y_a), 256'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 256'(job_ready_a), 256'd1);
      chk("post_rst_fifo_empty", 256'(hit_valid_a), 256'd0);
      chk("final_queues", 256'(q_a.size() + q_b.size()), 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/miner_job_scheduler.md
Name: miner_job_scheduler

Overview:
- Parametrised job controller between the UART multibyte receiver and transmitter and an array of dsha_finisher cores.
- Latches a mining job (X, Y, start nonce), sweeps a nonce range across NUM_CORES fixed-latency cores, and discards results from aborted jobs.
- Tests each result hash against a runtime leading-zero difficulty and queues hits in a FIFO for transmission.
- Replaces the single-core, fixed-difficulty, always-requesting top-level hookup.

Parameters:
- NUM_CORES, 1, number of parallel dsha_finisher cores; power of two, 1..8.
- PIPE_LATENCY, 64, cycles from core input nonce to matching hash/out_nonce output.
- NONCE_SPAN_LOG2, 32, log2 of nonces swept per job; >= log2(NUM_CORES).
- HIT_DEPTH, 4, hit FIFO entries; power of two.

Ports:
- clk  in  1  system clock (10 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  new job strobe; job_ready is always 1.
- job_ready  out  1  constant 1 after reset.
- job_x  in  256  midstate X.
- job_y  in  96  tail Y.
- job_nonce_start  in  32  first nonce.
- zero_bits  in  9  required leading zero bits of hash, 0..256; sampled with the job.
- core_x  out  256  broadcast X to all cores.
- core_y  out  96  broadcast Y to all cores.
- core_nonce  out  32*NUM_CORES  per-core input nonce, core i in bits [32i+31:32i].
- core_hash  in  256*NUM_CORES  per-core result hash.
- core_out_nonce  in  32*NUM_CORES  per-core result nonce.
- hit_valid  out  1  FIFO head valid.
- hit_ready  in  1  consumer pop.
- hit_hash  out  256  head hash.
- hit_nonce  out  32  head nonce.
- busy  out  1  state != IDLE.
- exhausted  out  1  sticky: range finished; cleared by the next job.
- drop_count  out  8  saturating count of lost hits; cleared by the next job.

Behaviour:
- Reset values:
  - state IDLE; core_x, core_y, core_nonce all 0; valid pipe cleared; FIFO empty.
  - hit_valid 0, busy 0, exhausted 0, drop_count 0.
  - job_ready 1 from the first clk after rst_n deasserts.
- States:
  - IDLE: wait for a job.
  - SCAN: issue nonces every cycle.
  - DRAIN: range fully issued; wait for the valid pipe to empty.
- job_valid in any state, including SCAN and DRAIN:
  - Latch X, Y and zero_bits; base <= job_nonce_start; issue count <= 0.
  - Clear the whole valid pipe so in-flight results from the old job are never tested.
  - Clear exhausted and drop_count; go to SCAN next cycle.
  - FIFO contents are kept.
- SCAN, each cycle:
  - core i gets base + i, mod 2^32 wrap allowed.
  - base += NUM_CORES; count += NUM_CORES (count is NONCE_SPAN_LOG2+1 bits).
  - Shift 1 into the valid pipe.
  - When count reaches 2^NONCE_SPAN_LOG2 after the increment, go to DRAIN.
- DRAIN: shift 0 into the valid pipe. When the pipe is all zero, set exhausted and go to IDLE.
- Valid pipe: PIPE_LATENCY bits, one per issue cycle. Its output qualifies core_hash/core_out_nonce of all cores in the same cycle.
- Hit test: the hash qualifies when hash[255 -: zero_bits] == 0. zero_bits = 0 makes every result a hit; 256 requires an all-zero hash.
- Several cores hit in one cycle: the lowest index is pushed; each other hit increments drop_count.
- FIFO full on push: the hit is dropped and drop_count increments, saturating at 255.
- Push and pop in the same cycle while full: the pop frees space, so the push succeeds.
- hit_* outputs are registered FIFO head; hit_nonce is core_out_nonce, not recomputed.
- Latency: a nonce issued at cycle t whose result qualifies appears on hit_valid at t + PIPE_LATENCY + 2, measured on an empty FIFO (1 registered compare stage + 1 FIFO write).

Optional Feature:
- Macro: MINER_SCHED_STATS_EN.
- Defined: adds output hash_count [47:0], the number of qualified results tested since reset. It is not cleared by a job, wraps at 2^48, and adds 1 register stage before it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package miner_pkg holds:
  - HASH_W = 256, NONCE_W = 32, X_W = 256, Y_W = 96.
  - State enum {IDLE, SCAN, DRAIN}.
  - Hit record typedef {hash, nonce}.
- Sub-module hit_fifo: synchronous FIFO of hit records.
  - Parameters: DEPTH.
  - Ports: push, pop, full, empty, head.

Test Plan:
- NUM_CORES=1, PIPE_LATENCY=4, NONCE_SPAN_LOG2=3, start 32'hFFFFFFFE, zero_bits=0, model core = delay line with hash = {224'h0, nonce} -> 8 hits with nonces FFFFFFFE, FFFFFFFF, 0..5 in order; exhausted set; busy falls 8+4 cycles after SCAN entry.
- NUM_CORES=4, model core returns an all-zero hash only for nonce 32'h10, zero_bits=24, start 0, span 2^5 -> exactly one hit, nonce 10, hash 0; drop_count 0.
- New job mid-SCAN with 3 results in flight that would all hit -> none of the old results appear; the new sweep restarts at the new start nonce.
- HIT_DEPTH=4, hit_ready held 0, 6 hits -> FIFO holds the first 4 and drop_count = 2. Then pulse hit_ready while a push arrives full -> accepted, no drop.
- 2 cores hit in the same cycle -> only the core-0 nonce is queued and drop_count increments by 1.
- rst_n asserted mid-DRAIN -> next cycle all outputs at reset values and FIFO empty; after release, job_ready is 1.
